// File: rtl/fsm_1100.sv
// Moore detector for the serial sequence 1,1,0,0; pulse is registered, one cycle after the final 0 is sampled.
// No backpressure: one bit is consumed every clock.
module fsm_1100 (
  input  logic clk,
  input  logic rst,
  input  logic bit_in,
  output logic pattern_detected
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_1    = 3'd1,
    S_11   = 3'd2,
    S_110  = 3'd3,
    S_DET  = 3'd4
  } state_t;

  state_t state;

  function automatic state_t next_state(input state_t cur, input logic b);
    state_t nxt;
    nxt = S_IDLE;
    case (cur)
      S_IDLE: nxt = b ? S_1   : S_IDLE;
      S_1:    nxt = b ? S_11  : S_IDLE;
      S_11:   nxt = b ? S_11  : S_110;
      S_110:  nxt = b ? S_1   : S_DET;
      S_DET:  nxt = b ? S_1   : S_IDLE;
      // Unused encodings fall back to idle with the output low.
      default: nxt = S_IDLE;
    endcase
    return nxt;
  endfunction

  // Output is registered alongside the state so it tracks S_DET exactly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= S_IDLE;
      pattern_detected <= 1'b0;
    end else begin
      state            <= next_state(state, bit_in);
      pattern_detected <= (next_state(state, bit_in) == S_DET);
    end
  end

endmodule

// File: tb/tb_fsm_1100.sv
// Bench for fsm_1100: sliding-window reference model plus directed literal streams and random traffic.
module tb_fsm_1100;

  logic clk;
  logic rst;
  logic bit_in;
  logic pattern_detected;

  int checks;
  int errors;
  bit cmp_en;

  // Reference: last four bits since reset and how many have been seen.
  logic [3:0] hist;
  int         seen;
  logic       exp_det;

  fsm_1100 dut (
    .clk              (clk),
    .rst              (rst),
    .bit_in           (bit_in),
    .pattern_detected (pattern_detected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist = 4'b0000;
      seen = 0;
    end else begin
      hist = {hist[2:0], bit_in};
      if (seen < 4) seen = seen + 1;
    end
  end

  assign exp_det = (seen >= 4) && (hist == 4'b1100);

  always @(negedge clk) begin
    if (cmp_en) begin
      checks++;
      if (pattern_detected !== exp_det) begin
        errors++;
        $display("FAIL model_cmp t=%0t got=%b want=%b", $time, pattern_detected, exp_det);
      end
    end
  end

  task automatic check_lit(input string name, input logic want);
    checks++;
    if (pattern_detected !== want) begin
      errors++;
      $display("FAIL %s t=%0t got=%b want=%b", name, $time, pattern_detected, want);
    end
  endtask

  // Entered and left at negedge+1; drives one bit and optionally checks the literal result.
  task automatic step(input logic b, input bit chk, input logic want, input string name);
    bit_in = b;
    @(posedge clk);
    #2;
    if (chk) check_lit(name, want);
    @(negedge clk);
    #1;
  endtask

  task automatic async_reset(input string name);
    rst = 1'b0;
    #1;
    check_lit(name, 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic run_stream(input string name, input logic [15:0] s, input int len,
                            input logic [15:0] mask);
    @(posedge clk);
    #2;
    async_reset({name, "_rst"});
    for (int i = 0; i < len; i++) begin
      step(s[len-1-i], 1'b1, mask[len-1-i], name);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cmp_en = 1'b0;
    bit_in = 1'b0;
    rst    = 1'b1;
    #1 rst = 1'b0;
    #2 check_lit("reset_out", 1'b0);
    @(negedge clk);
    cmp_en = 1'b1;
    #1;
    check_lit("reset_hold", 1'b0);
    rst = 1'b1;
    step(1'b0, 1'b1, 1'b0, "release_no_pulse");

    run_stream("basic_1100",     16'b11000,      5,  16'b00010);
    run_stream("no_match",       16'b0110110110, 10, 16'b0000000000);
    run_stream("long_ones",      16'b1111000,    7,  16'b0000010);
    run_stream("back_to_back",   16'b110011000,  9,  16'b000100010);
    run_stream("restart_in_110", 16'b11011000,   8,  16'b00000010);

    // Reset asserted between edges while in the "110" state.
    run_stream("pre_rst", 16'b110, 3, 16'b000);
    @(posedge clk);
    #2;
    async_reset("mid_seq_rst");
    step(1'b0, 1'b1, 1'b0, "post_rst_zero");
    step(1'b1, 1'b1, 1'b0, "post_rst_a");
    step(1'b1, 1'b1, 1'b0, "post_rst_b");
    step(1'b0, 1'b1, 1'b0, "post_rst_c");
    step(1'b0, 1'b1, 1'b1, "post_rst_det");

    // Reset while the pulse is high must clear it immediately.
    async_reset("rst_during_pulse");
    step(1'b0, 1'b1, 1'b0, "after_pulse_rst");

    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0, 1'b0, 1'b0, "rand");
      if ($urandom_range(0, 199) == 0) begin
        @(posedge clk);
        #2;
        async_reset("rand_rst");
      end
    end

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsm_1100.md
FSM_1100 -- requirements
Module: fsm_1100

Interface
- REQ-001: The block SHALL have no parameters.
- REQ-002: clk  input  1  single clock; all state updates on rising edge.
- REQ-003: rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- REQ-004: bit_in  input  1  serial data bit, sampled on each rising clk edge.
- REQ-005: pattern_detected  output  1  registered one-cycle pulse when the serial sequence 1,1,0,0 has completed.

Function
- REQ-006: The block SHALL be a Moore FSM whose output depends only on the current state.
- REQ-007: States SHALL be:
  - S_IDLE: no progress.
  - S_1: seen "1".
  - S_11: seen "11".
  - S_110: seen "110".
  - S_DET: seen "1100".
- REQ-008: Transitions from S_IDLE: bit_in=1 -> S_1; bit_in=0 -> S_IDLE.
- REQ-009: Transitions from S_1: 1 -> S_11; 0 -> S_IDLE.
- REQ-010: Transitions from S_11: 1 -> S_11 (any run of 1s keeps the "11" prefix); 0 -> S_110.
- REQ-011: Transitions from S_110: 0 -> S_DET; 1 -> S_1.
- REQ-012: Transitions from S_DET: 1 -> S_1; 0 -> S_IDLE.
- REQ-013: pattern_detected SHALL be 1 exactly while the state is S_DET, else 0.
- REQ-014: Latency: pattern_detected SHALL rise in the cycle after the clock edge that samples the final 0 of "1100".
- REQ-015: pattern_detected SHALL stay high for exactly one cycle per detection.
- REQ-016: Overlapping occurrences SHALL be detected. "1100" has no self-overlap, so consecutive detections are at least 4 cycles apart; "11001100" yields two pulses 4 cycles apart.
- REQ-017: Detection SHALL follow the last 4 sampled bits only. Earlier history SHALL have no effect beyond the transitions above (e.g. "111100" detects).
- REQ-018: An unknown or X value on bit_in SHALL NOT be relied upon; the bench drives bit_in to 0 or 1 before the first sampling edge after reset release.
- REQ-019: Unused state encodings, if any, SHALL transition to S_IDLE on the next edge with pattern_detected = 0.

Reset
- REQ-020: While rst = 0, the state SHALL be S_IDLE and pattern_detected SHALL be 0, immediately and without waiting for a clk edge.
- REQ-021: Asserting reset mid-sequence (for example in S_110) SHALL discard all partial progress; after release, detection SHALL require a complete new "1100".
- REQ-022: After rst returns to 1, the first rising clk edge SHALL sample bit_in normally.
- REQ-023: Reset release SHALL NOT itself generate a pulse.

Verification
- REQ-024: Reset, then bit_in = 1,1,0,0 on successive edges -> pattern_detected = 1 for one cycle after the 4th edge, 0 otherwise.
- REQ-025: Stream 0,1,1,0,1,1,0,1,1,0 -> pattern_detected stays 0 throughout.
- REQ-026: Stream 1,1,1,1,0,0 -> a single pulse after the 6th edge.
- REQ-027: Stream 1,1,0,0,1,1,0,0 -> two one-cycle pulses, after edge 4 and edge 8.
- REQ-028: Stream 1,1,0, then rst = 0 asynchronously between edges, then release and drive 0 -> no pulse; pattern_detected = 0 immediately on reset assertion.
- REQ-029: Stream 1,1,0,1,1,0,0 -> exactly one pulse, after edge 7.
